// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED register, synchronised and debounced switches and
// buttons, and sticky button-press flags cleared by writing 1.
module mmio_gpio #(
  parameter int LED_W    = 16,
  parameter int SW_W     = 16,
  parameter int BTN_N    = 4,
  parameter int DEBOUNCE = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        io_bus_addr,
  input  logic              io_bus_wrEn,
  input  logic [31:0]       io_bus_wrData,
  input  logic              io_bus_rdEn,
  output logic [31:0]       io_bus_rdData,
  input  logic [SW_W-1:0]   io_switches,
  input  logic [BTN_N-1:0]  io_buttons,
  output logic [LED_W-1:0]  io_leds
);

  localparam int IN_W  = SW_W + BTN_N;
  localparam int CNT_W = $clog2(DEBOUNCE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_SW     = 2'd1,
    REG_BTN    = 2'd2,
    REG_BTNCLR = 2'd3
  } reg_sel_e;

  // Switches and buttons share one input path: buttons occupy the upper bits.
  logic [IN_W-1:0]  w_raw;
  logic [IN_W-1:0]  r_s1, r_s2, r_stable, w_stable_nxt;
  logic [CNT_W-1:0] r_cnt     [IN_W];
  logic [CNT_W-1:0] w_cnt_nxt [IN_W];

  logic [LED_W-1:0] r_leds;
  logic [BTN_N-1:0] r_flags, w_flag_set, w_flag_clr;
  logic [BTN_N-1:0] w_btn;
  logic [SW_W-1:0]  w_sw;
  logic [31:0]      r_rd_data, w_rd_mux;
  reg_sel_e         w_sel;
  logic             w_unused_bits;

  assign w_raw = {io_buttons, io_switches};
  assign w_sel = reg_sel_e'(io_bus_addr[3:2]);
  assign w_sw  = r_stable[SW_W-1:0];
  assign w_btn = r_stable[IN_W-1:SW_W];

  // Byte-lane bits and unmapped write bits are deliberately ignored.
  assign w_unused_bits = &{io_bus_addr[1:0], io_bus_wrData};

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < IN_W; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_stable_nxt[i] = r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A flag sets on the same edge the debounced button rises; set beats clear.
  assign w_flag_set = w_stable_nxt[IN_W-1:SW_W] & ~w_btn;
  assign w_flag_clr = (io_bus_wrEn && (w_sel == REG_BTNCLR)) ?
                      io_bus_wrData[16 +: BTN_N] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      REG_LED:    w_rd_mux[LED_W-1:0] = r_leds;
      REG_SW:     w_rd_mux[SW_W-1:0]  = w_sw;
      REG_BTN: begin
        w_rd_mux[BTN_N-1:0]  = w_btn;
        w_rd_mux[16 +: BTN_N] = r_flags;
      end
      REG_BTNCLR: w_rd_mux[16 +: BTN_N] = r_flags;
      default:    w_rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_stable  <= '0;
      r_leds    <= '0;
      r_flags   <= '0;
      r_rd_data <= '0;
      // NOTE: the counter array is small flop storage, so it is reset element by element.
      for (int i = 0; i < IN_W; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1     <= w_raw;
      r_s2     <= r_s1;
      r_stable <= w_stable_nxt;
      for (int i = 0; i < IN_W; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      if (io_bus_wrEn && (w_sel == REG_LED)) begin
        r_leds <= io_bus_wrData[LED_W-1:0];
      end
      r_flags   <= (r_flags & ~w_flag_clr) | w_flag_set;
      r_rd_data <= io_bus_rdEn ? w_rd_mux : 32'h0;
    end
  end

  assign io_leds       = r_leds;
  assign io_bus_rdData = r_rd_data;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed self-checking bench for mmio_gpio with DEBOUNCE=4.
module tb_mmio_gpio;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  io_bus_addr;
  logic        io_bus_wrEn;
  logic [31:0] io_bus_wrData;
  logic        io_bus_rdEn;
  logic [31:0] io_bus_rdData;
  logic [15:0] io_switches;
  logic [3:0]  io_buttons;
  logic [15:0] io_leds;

  int checks = 0;
  int errors = 0;

  mmio_gpio #(
    .LED_W(16), .SW_W(16), .BTN_N(4), .DEBOUNCE(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_bus_addr   (io_bus_addr),
    .io_bus_wrEn   (io_bus_wrEn),
    .io_bus_wrData (io_bus_wrData),
    .io_bus_rdEn   (io_bus_rdEn),
    .io_bus_rdData (io_bus_rdData),
    .io_switches   (io_switches),
    .io_buttons    (io_buttons),
    .io_leds       (io_leds)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    io_bus_addr   = addr;
    io_bus_wrData = data;
    io_bus_wrEn   = 1'b1;
    tick();
    io_bus_wrEn   = 1'b0;
    io_bus_wrData = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    io_bus_addr = addr;
    io_bus_rdEn = 1'b1;
    tick();
    io_bus_rdEn = 1'b0;
    data = io_bus_rdData;
  endtask

  initial begin
    logic [31:0] rd;

    reset         = 1'b1;
    io_bus_addr   = 4'h0;
    io_bus_wrEn   = 1'b0;
    io_bus_wrData = 32'h0;
    io_bus_rdEn   = 1'b0;
    io_switches   = 16'h0;
    io_buttons    = 4'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and empty register reads.
    check("reset_leds", {16'h0, io_leds}, 32'h0);
    check("reset_rddata", io_bus_rdData, 32'h0);
    bus_read(4'h0, rd); check("rd_led_reset", rd, 32'h0);
    bus_read(4'h4, rd); check("rd_sw_reset", rd, 32'h0);
    bus_read(4'h8, rd); check("rd_btn_reset", rd, 32'h0);
    bus_read(4'hC, rd); check("rd_clr_reset", rd, 32'h0);

    // LED write, upper bits ignored; SW is read-only; rdData idles at 0.
    bus_write(4'h0, 32'hFFFFA5A5);
    check("leds_after_write", {16'h0, io_leds}, 32'h0000A5A5);
    bus_read(4'h0, rd); check("rd_led", rd, 32'h0000A5A5);
    tick();
    check("rddata_idle", io_bus_rdData, 32'h0);
    bus_write(4'h4, 32'h12345678);
    bus_read(4'h4, rd); check("rd_sw_ro", rd, 32'h0);
    bus_read(4'h1, rd); check("rd_led_lowbits_ignored", rd, 32'h0000A5A5);

    // Switch latency: first sampled at edge k, visible to reads after edge k+5.
    io_switches = 16'h1234;
    io_bus_addr = 4'h4;
    io_bus_rdEn = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("sw_latency_%0d", j), io_bus_rdData, (j <= 5) ? 32'h0 : 32'h00001234);
    end
    io_bus_rdEn = 1'b0;

    // Bouncing button 0: two-cycle pulses never reach the debounce count.
    io_bus_addr = 4'h8;
    io_bus_rdEn = 1'b1;
    for (int seg = 0; seg < 10; seg++) begin
      io_buttons[0] = (seg % 2 == 0);
      tick();
      check($sformatf("bounce_%0d_a", seg), io_bus_rdData, 32'h0);
      tick();
      check($sformatf("bounce_%0d_b", seg), io_bus_rdData, 32'h0);
    end
    io_buttons[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("btn0_settle_%0d", j), io_bus_rdData, (j <= 5) ? 32'h0 : 32'h00010001);
    end
    io_bus_rdEn = 1'b0;
    bus_read(4'hC, rd); check("rd_clr_flag0", rd, 32'h00010000);

    // W1C of flag 0.
    bus_write(4'hC, 32'h00010000);
    bus_read(4'hC, rd); check("rd_clr_after_w1c", rd, 32'h0);
    bus_read(4'h8, rd); check("rd_btn_after_w1c", rd, 32'h00000001);

    // Button 1 rise on the same edge as its W1C: set wins; read sees pre-edge value.
    io_buttons[1] = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    io_bus_addr   = 4'hC;
    io_bus_wrData = 32'h00020000;
    io_bus_wrEn   = 1'b1;
    io_bus_rdEn   = 1'b1;
    tick();
    io_bus_wrEn   = 1'b0;
    io_bus_rdEn   = 1'b0;
    io_bus_wrData = 32'h0;
    check("rd_during_set_clr", io_bus_rdData, 32'h0);
    bus_read(4'hC, rd); check("set_beats_clear", rd, 32'h00020000);

    // Release of button 1 leaves its flag alone.
    io_buttons[1] = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    bus_read(4'hC, rd); check("release_keeps_flag", rd, 32'h00020000);
    bus_read(4'h8, rd); check("rd_btn_after_release", rd, 32'h00020001);

    // Reset mid-debounce of button 2 discards the partial count.
    io_buttons = 4'b0100;
    for (int j = 0; j < 4; j++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_leds", {16'h0, io_leds}, 32'h0);
    check("midreset_rddata", io_bus_rdData, 32'h0);
    io_bus_addr = 4'hC;
    io_bus_rdEn = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check($sformatf("btn2_after_reset_%0d", j), io_bus_rdData, (j <= 6) ? 32'h0 : 32'h00040000);
    end
    io_bus_rdEn = 1'b0;
    bus_read(4'h4, rd); check("sw_after_reset", rd, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Memory-mapped GPIO peripheral for the RISCV32 SoC. It replaces the constant-driven board I/O of the simulation top with a bus-accessible block. It provides a writable LED register, synchronised and debounced switch and button inputs, and sticky button-press flags that software clears by writing 1. It sits on the core's data-memory bus next to the UART and seven-segment blocks and drives `io_leds` at the top level.

## Interface
Parameters:
- `LED_W`, 16, LED output width (1..32)
- `SW_W`, 16, switch input width (1..32)
- `BTN_N`, 4, button count (1..16)
- `DEBOUNCE`, 100000, consecutive stable cycles required before an input change is accepted (≥1)

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `io_bus_addr`  in  4  byte offset; bits [3:2] select the register, bits [1:0] are ignored
- `io_bus_wrEn`  in  1  write strobe, single cycle
- `io_bus_wrData`  in  32  write data
- `io_bus_rdEn`  in  1  read strobe, single cycle
- `io_bus_rdData`  out  32  read data, registered
- `io_switches`  in  SW_W  raw asynchronous switches
- `io_buttons`  in  BTN_N  raw asynchronous buttons, active-high
- `io_leds`  out  LED_W  LED register contents

## Operation
Register map:
- `0x0 LED` (RW): bits [LED_W-1:0] drive `io_leds`. Upper write bits are ignored; upper read bits return 0.
- `0x4 SW` (RO): debounced switch state in [SW_W-1:0]. Writes are ignored.
- `0x8 BTN` (RO): debounced button state in [BTN_N-1:0]; press flags in [16+BTN_N-1:16]. Writes are ignored.
- `0xC BTNCLR` (W1C): a write clears every flag whose bit [16+i] is 1 in `wrData`. A read returns the flags in [16+BTN_N-1:16] and 0 elsewhere.

Input path, applied per bit to switches and buttons independently:
- Two-flop synchroniser: `s1 <= in`, `s2 <= s1`.
- Debouncer, with counter width clog2(DEBOUNCE)+1:
  - if `s2 == stable`, `cnt <= 0`;
  - else if `cnt == DEBOUNCE-1`, `stable <= s2` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
- Any glitch back to the stable value restarts the count from 0.

Press flags:
- Flag i sets on the edge where debounced button i changes from 0 to 1.
- Flag i is cleared only by a W1C write to it.
- If a set and a clear of the same flag occur on the same edge, the set wins and the flag stays 1.
- Release (1→0) has no effect on the flag.

Bus:
- `wrEn` and `rdEn` may be asserted together. The read returns the value from before the write.
- The block never stalls. No ready or error signals.

## Timing
- Reset values:
  - `io_leds` = 0
  - `io_bus_rdData` = 0
  - all sync flops, stable states, counters and flags = 0
- Reset asserted mid-debounce discards the partial count; no update occurs.
- LED write at edge t: `io_leds` shows the new value after edge t, i.e. in cycle t+1.
- Read with `rdEn` high in cycle t: `io_bus_rdData` is valid after edge t and holds for one cycle. In any cycle not following an `rdEn` cycle, `rdData` = 0.
- Input latency: a raw change first sampled at edge k and held updates `stable` at edge k+DEBOUNCE+1. The matching flag sets on that same edge. The first read that reflects it is issued in the cycle after that edge.
- Counters saturate via the compare; they never wrap. Inputs held at the stable value leave `cnt` at 0 indefinitely.

## Test plan
(DEBOUNCE=4, defaults otherwise)
- Reset, then read 0x0, 0x4, 0x8 and 0xC with all inputs 0 -> every read returns 0x00000000 and `io_leds` = 0x0000.
- Write 0xFFFFA5A5 to 0x0 -> `io_leds` = 0xA5A5 the next cycle; read 0x0 -> 0x0000A5A5. Write 0x12345678 to 0x4 -> a read of 0x4 is unchanged.
- Drive `io_switches` = 0x1234, first sampled at edge k -> read 0x4 returns 0x0000 for reads issued through cycle k+5 and 0x1234 from the cycle after edge k+5.
- Toggle button 0 every 2 cycles for 20 cycles, then hold it at 1 -> BTN bit0 stays 0 throughout the bounce, then becomes 1 exactly DEBOUNCE+1 edges after the final transition. Read 0x8 -> 0x00010001.
- Write 0x00010000 to 0xC -> read 0xC returns 0. Then align a button-1 debounced rise with a W1C write of 0x00020000 on the same edge -> bit17 reads 1 afterwards.
- Hold button 2 high, assert `reset` for 1 cycle at count 2, release it, and keep button 2 high -> the flag sets DEBOUNCE+2 edges after reset deasserts, with no earlier update.
